// File: rtl/rle_pair_packer.sv
// Run-length pair packer: tracks the current run, packs finished runs into
// (value, count) pairs and buffers them in a small FIFO for the serializer.
module rle_pair_packer #(
   parameter int DATA_W  = 32,
   parameter int COUNT_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  data_in,
   input  logic               inc,
   input  logic               run_end,
   input  logic               flush,
   output logic               overflow,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_value,
   output logic [COUNT_W-1:0] out_count
);

   // state   | meaning
   // ST_IDLE | no run pending; next accepted word starts a run
   // ST_RUN  | run_value/run_cnt hold an open run
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [COUNT_W-1:0] MAX = '1;
   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   logic [0:0]         r_state;
   logic [COUNT_W-1:0] r_run_cnt;
   logic [DATA_W-1:0]  r_run_value;
   logic               r_flush_pend;
   logic [AW:0]        r_wr_ptr;
   logic [AW:0]        r_rd_ptr;
   logic [DATA_W-1:0]  r_mem_val [DEPTH];
   logic [COUNT_W-1:0] r_mem_cnt [DEPTH];

   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_pop;
   logic               w_flush_now;
   logic               w_push;
   logic [DATA_W-1:0]  w_push_val;
   logic [COUNT_W-1:0] w_push_cnt;
   logic [0:0]         w_nxt_state;
   logic [COUNT_W-1:0] w_nxt_cnt;
   logic [DATA_W-1:0]  w_nxt_val;

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign in_ready    = !w_full;
   assign w_accept    = in_valid && !w_full;
   assign out_valid   = !w_empty;
   assign w_pop       = out_valid && out_ready;
   assign overflow    = (r_state == ST_RUN) && (r_run_cnt == MAX);
   assign out_value   = r_mem_val[r_rd_ptr[AW-1:0]];
   assign out_count   = r_mem_cnt[r_rd_ptr[AW-1:0]];
   // A flush that arrived while full completes on the first non-full cycle.
   assign w_flush_now = (r_state == ST_RUN) && (flush || r_flush_pend) && !w_full;

   always_comb begin
      w_push      = 1'b0;
      w_push_val  = r_run_value;
      w_push_cnt  = r_run_cnt;
      w_nxt_state = r_state;
      w_nxt_cnt   = r_run_cnt;
      w_nxt_val   = r_run_value;
      if (r_state == ST_IDLE) begin
         if (w_accept) begin
            w_nxt_val   = data_in;
            w_nxt_cnt   = ONE;
            w_nxt_state = ST_RUN;
         end
      end else begin
         if (w_accept) begin
            if (run_end) begin
               w_push    = 1'b1;
               w_nxt_val = data_in;
               w_nxt_cnt = ONE;
            end else if (inc) begin
               if (r_run_cnt == MAX) begin
                  w_push    = 1'b1;
                  w_nxt_cnt = ONE;
               end else begin
                  w_nxt_cnt = r_run_cnt + ONE;
               end
            end
         end
         // Only one push per cycle: a flush that coincides with a run-ending
         // word emits the ended run and closes without opening a new one.
         if (w_flush_now) begin
            if (!w_push) begin
               w_push     = 1'b1;
               w_push_val = w_nxt_val;
               w_push_cnt = w_nxt_cnt;
            end
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_run_cnt    <= '0;
         r_run_value  <= '0;
         r_flush_pend <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_run_cnt    <= w_nxt_cnt;
         r_run_value  <= w_nxt_val;
         r_flush_pend <= (r_state == ST_RUN) && (flush || r_flush_pend) && w_full;
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_val[i] <= '0;
            r_mem_cnt[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_val[r_wr_ptr[AW-1:0]] <= w_push_val;
         r_mem_cnt[r_wr_ptr[AW-1:0]] <= w_push_cnt;
      end
   end

endmodule

// File: tb/tb_rle_pair_packer.sv
// Directed bench for rle_pair_packer (COUNT_W=4 so saturation is short).
module tb_rle_pair_packer;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic        inc;
   logic        run_end;
   logic        flush;
   logic        overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic [3:0]  out_count;

   int n_cmp = 0;
   int n_err = 0;
   int vcnt  = 0;
   logic [31:0] q_val [$];
   logic [3:0]  q_cnt [$];
   int q0;
   int v0;

   rle_pair_packer #(.DATA_W(32), .COUNT_W(4), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .inc(inc), .run_end(run_end), .flush(flush),
      .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
      .out_value(out_value), .out_count(out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Records every pair handed over, plus cycles with out_valid high.
   always @(posedge clock) begin
      if (!reset) begin
         if (out_valid) vcnt <= vcnt + 1;
         if (out_valid && out_ready) begin
            q_val.push_back(out_value);
            q_cnt.push_back(out_count);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic i,
                        input logic re, input logic f);
      in_valid = v;
      data_in  = d;
      inc      = i;
      run_end  = re;
      flush    = f;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pair(input string tag, input int idx, input logic [31:0] v,
                           input logic [3:0] c);
      logic [35:0] obs;
      obs = (idx < q_val.size()) ? {q_val[idx], q_cnt[idx]} : 36'hF_FFFF_FFFF;
      chk(tag, {28'd0, obs}, {28'd0, v, c});
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      drive(0, 32'h0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      chk("rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst out_value", {32'd0, out_value}, 64'd0);
      chk("rst out_count", {60'd0, out_count}, 64'd0);
      chk("rst overflow",  {63'd0, overflow},  64'd0);
      chk("rst in_ready",  {63'd0, in_ready},  64'd1);

      // Run of three identical words, then a single zero, then flush.
      out_ready = 1'b1;
      q0 = q_val.size();
      v0 = vcnt;
      drive(1, 32'hAAAAAAAA, 0, 0, 0); tick();
      drive(1, 32'hAAAAAAAA, 1, 0, 0); tick();
      tick();
      chk("t1 no overflow", {63'd0, overflow}, 64'd0);
      drive(1, 32'h00000000, 0, 1, 0); tick();
      chk("t1 head valid", {63'd0, out_valid}, 64'd1);
      chk("t1 head count", {60'd0, out_count}, 64'd3);
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      tick(); tick();
      chk("t1 pair count", 64'(q_val.size() - q0), 64'd2);
      chk_pair("t1 pair0", q0,     32'hAAAAAAAA, 4'd3);
      chk_pair("t1 pair1", q0 + 1, 32'h00000000, 4'd1);
      chk("t1 valid cycles", 64'(vcnt - v0), 64'd2);

      // Saturation at 15 with COUNT_W=4.
      q0 = q_val.size();
      drive(1, 32'hFFFFFFFF, 0, 0, 0); tick();
      for (int k = 2; k <= 14; k++) begin
         drive(1, 32'hFFFFFFFF, 1, 0, 0); tick();
      end
      chk("t2 overflow at 14", {63'd0, overflow}, 64'd0);
      tick();
      chk("t2 overflow at 15", {63'd0, overflow}, 64'd1);
      chk("t2 nothing pushed", {63'd0, out_valid}, 64'd0);
      tick();
      chk("t2 overflow cleared", {63'd0, overflow}, 64'd0);
      chk("t2 sat count", {60'd0, out_count}, 64'd15);
      tick();
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      tick();
      chk("t2 pair count", 64'(q_val.size() - q0), 64'd2);
      chk_pair("t2 pair0", q0,     32'hFFFFFFFF, 4'd15);
      chk_pair("t2 pair1", q0 + 1, 32'hFFFFFFFF, 4'd2);

      // Backpressure: fill the FIFO, then drain in order.
      out_ready = 1'b0;
      q0 = q_val.size();
      drive(1, 32'hA0A0A0A0, 0, 1, 0); tick();
      drive(1, 32'h0A0A0A0A, 0, 1, 0); tick();
      drive(1, 32'hA0A0A0A0, 0, 1, 0); tick();
      drive(1, 32'h0A0A0A0A, 0, 1, 0); tick();
      chk("t3 ready after 3", {63'd0, in_ready}, 64'd1);
      drive(1, 32'hA0A0A0A0, 0, 1, 0); tick();
      chk("t3 ready after 4", {63'd0, in_ready}, 64'd0);
      drive(1, 32'h0A0A0A0A, 0, 1, 0); tick();
      chk("t3 still blocked", {63'd0, in_ready}, 64'd0);
      chk("t3 head stable", {28'd0, out_value, out_count}, {28'd0, 32'hA0A0A0A0, 4'd1});
      drive(0, 32'h0, 0, 0, 0);
      out_ready = 1'b1;
      tick(); tick(); tick(); tick();
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      tick();
      chk("t3 pair count", 64'(q_val.size() - q0), 64'd5);
      chk_pair("t3 pair0", q0,     32'hA0A0A0A0, 4'd1);
      chk_pair("t3 pair1", q0 + 1, 32'h0A0A0A0A, 4'd1);
      chk_pair("t3 pair2", q0 + 2, 32'hA0A0A0A0, 4'd1);
      chk_pair("t3 pair3", q0 + 3, 32'h0A0A0A0A, 4'd1);
      chk_pair("t3 pair4", q0 + 4, 32'hA0A0A0A0, 4'd1);

      // run_end and inc together: run_end wins.
      q0 = q_val.size();
      drive(1, 32'hDEADBEEF, 0, 0, 0); tick();
      drive(1, 32'h12345678, 1, 1, 0); tick();
      chk("t4 head", {28'd0, out_value, out_count}, {28'd0, 32'hDEADBEEF, 4'd1});
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      tick();
      chk("t4 pair count", 64'(q_val.size() - q0), 64'd2);
      chk_pair("t4 pair1", q0 + 1, 32'h12345678, 4'd1);

      // Reset with two pairs buffered and a run of five pending.
      out_ready = 1'b0;
      drive(1, 32'h11111111, 0, 0, 0); tick();
      drive(1, 32'h22222222, 0, 1, 0); tick();
      drive(1, 32'h33333333, 0, 1, 0); tick();
      drive(1, 32'h33333333, 1, 0, 0); tick(); tick(); tick(); tick();
      chk("t5 buffered", {63'd0, out_valid}, 64'd1);
      drive(0, 32'h0, 0, 0, 0);
      reset = 1'b1; tick();
      reset = 1'b0;
      chk("t5 out_valid", {63'd0, out_valid}, 64'd0);
      chk("t5 overflow",  {63'd0, overflow},  64'd0);
      chk("t5 in_ready",  {63'd0, in_ready},  64'd1);
      drive(1, 32'h55555555, 0, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0);
      chk("t5 fresh run", {27'd0, out_valid, out_value, out_count}, {27'd0, 1'b1, 32'h55555555, 4'd1});
      out_ready = 1'b1;
      tick(); tick();

      // Flush while full; consumer wakes three cycles later.
      out_ready = 1'b0;
      q0 = q_val.size();
      drive(1, 32'hB0B0B0B0, 0, 0, 0); tick();
      drive(1, 32'hB1B1B1B1, 0, 1, 0); tick();
      drive(1, 32'hB2B2B2B2, 0, 1, 0); tick();
      drive(1, 32'hB3B3B3B3, 0, 1, 0); tick();
      drive(1, 32'hB4B4B4B4, 0, 1, 0); tick();
      chk("t6 full", {63'd0, in_ready}, 64'd0);
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0); tick();
      chk("t6 blocked 1", {63'd0, in_ready}, 64'd0);
      tick();
      chk("t6 blocked 2", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      chk("t6 head after pop", {28'd0, out_value, out_count}, {28'd0, 32'hB1B1B1B1, 4'd1});
      tick();
      chk("t6 refilled", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("t6 pair count", 64'(q_val.size() - q0), 64'd5);
      chk_pair("t6 pair0", q0,     32'hB0B0B0B0, 4'd1);
      chk_pair("t6 pair3", q0 + 3, 32'hB3B3B3B3, 4'd1);
      chk_pair("t6 pair4", q0 + 4, 32'hB4B4B4B4, 4'd1);
      chk("t6 drained", {63'd0, out_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
